enc_param_serial: RTL and testbench
===================================

Name: enc_param_serial

Overview:
- Parameterized bit-vector-to-index encoder. It is the inverse of the team's one-hot decoder.
- Latches a multi-hot vector of 2**n bits on a load strobe.
- Emits the index of every set bit, lowest first, one per valid/ready handshake.
- Sits between status/request registers and index-consuming logic, e.g. a decoder-driven select bus.

Parameters:
- n, 3, index width; the vector width is 2**n bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- vec_in  input  2**n  vector to encode; sampled only on an accepted load.
- load  input  1  load strobe; accepted only in IDLE.
- busy  output  1  high while a latched vector is being emitted (state SCAN).
- idx_out  output  n  index of the current lowest pending set bit; registered.
- valid  output  1  idx_out is valid; registered.
- ready  input  1  consumer accepts idx_out when valid && ready at a rising edge.
- done  output  1  one-cycle pulse after the last index is accepted, or after a zero vector is loaded.
- empty  output  1  set with done when the loaded vector was zero; held until the next accepted load.
- cnt  output  n+1  number of indices accepted since the last load; range 0..2**n.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, internal pend=0.
  - idx_out=0, valid=0, busy=0, done=0, empty=0, cnt=0.
- Reset mid-emission aborts the vector. No done pulse is produced.
- States:
  - IDLE: busy=0, valid=0.
  - SCAN: busy=1, valid=1.
- IDLE with load=1, at the rising edge:
  - pend<=vec_in and cnt<=0.
  - If vec_in!=0: go to SCAN. idx_out<=lowest set index of vec_in and valid<=1, both visible the cycle after load (latency 1). empty<=0.
  - If vec_in==0: stay in IDLE. done<=1 for one cycle and empty<=1.
- SCAN, valid && ready at the rising edge:
  - Clear bit idx_out in pend and increment cnt.
  - If other bits remain: idx_out<=lowest remaining set index; valid stays 1. Throughput is one index per cycle with ready held high.
  - If no bits remain: go to IDLE, valid<=0, busy<=0, done<=1 for exactly one cycle.
- SCAN with ready=0: idx_out, valid, pend and cnt all hold. Valid never drops without a handshake.
- Ignored inputs:
  - load while busy is ignored; vec_in changes have no effect on pend.
  - ready while valid=0 is ignored.
- done and load in the same cycle (IDLE): the load is accepted normally. The done pulse still ends after one cycle.
- Output order is strictly ascending. Each set bit is emitted exactly once; cleared bits are never emitted.
- cnt at done equals the popcount of the loaded vector. It holds until the next accepted load.
- The lowest-set-bit search is combinational over pend (priority from bit 0). idx_out is the registered result.

Test Plan:
- n=3, load vec_in=8'b1010_0100, ready=1 -> valid cycles t+1..t+3 with idx_out 2,5,7; done pulse at t+4; cnt=3; empty=0.
- load vec_in=8'h00 -> valid never asserts; done=1 and empty=1 at t+1; done=0 at t+2; cnt=0; busy stays 0.
- load 8'b0001_0010, ready=0 for 3 cycles then 1 -> idx_out=1 held stable with valid=1 for 4 cycles; then idx_out=4 for one cycle; then done; cnt=2.
- load 8'hFF with ready=1 -> idx_out 0..7 on 8 consecutive cycles; done the cycle after; cnt=8. A second load of 8'h01 during SCAN is ignored (no index 0 re-emitted after 7).
- load 8'hF0, accept idx 4, assert rst asynchronously mid-cycle -> all outputs 0 immediately, no done. After rst drops, load 8'h80 -> single idx 7, then done.
- Final accept and a new load of 8'h03 in back-to-back cycles -> done pulse, then idx_out 0,1; cnt resets to 0 on the load, ends at 2.

Source files
------------

// File: rtl/enc_param_serial.sv
// Multi-hot vector to index serializer: latches a 2**n-bit vector on load
// and emits the index of each set bit, lowest first, over valid/ready.
module enc_param_serial #(
  parameter int n = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**n-1:0] vec_in,
  input  logic            load,
  output logic            busy,
  output logic [n-1:0]    idx_out,
  output logic            valid,
  input  logic            ready,
  output logic            done,
  output logic            empty,
  output logic [n:0]      cnt
);

  localparam int W = 2**n;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pend_q, pend_d;
  logic [n-1:0]   idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           empty_q, empty_d;
  logic [n:0]     cnt_q, cnt_d;

  logic [W-1:0]   cur_bit;
  logic [W-1:0]   pend_rest;
  logic [n-1:0]   low_vec;
  logic [n-1:0]   low_rest;

  // Priority from bit 0: a descending scan leaves the lowest hit last.
  function automatic logic [n-1:0] lowest(input logic [W-1:0] v);
    logic [n-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) r = i[n-1:0];
    end
    return r;
  endfunction

  assign cur_bit   = {{(W-1){1'b0}}, 1'b1} << idx_q;
  assign pend_rest = pend_q & ~cur_bit;
  assign low_vec   = lowest(vec_in);
  assign low_rest  = lowest(pend_rest);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    empty_d = empty_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          pend_d = vec_in;
          cnt_d  = '0;
          if (|vec_in) begin
            state_d = SCAN;
            idx_d   = low_vec;
            valid_d = 1'b1;
            empty_d = 1'b0;
          end else begin
            done_d  = 1'b1;
            empty_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (valid_q && ready) begin
          pend_d = pend_rest;
          cnt_d  = cnt_q + {{n{1'b0}}, 1'b1};
          if (|pend_rest) begin
            idx_d = low_rest;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      empty_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == SCAN);
  assign idx_out = idx_q;
  assign valid   = valid_q;
  assign done    = done_q;
  assign empty   = empty_q;
  assign cnt     = cnt_q;

endmodule

// File: tb/tb_enc_param_serial.sv
// Directed bench for enc_param_serial (n=3): vector table plus
// stall, ignored-load, async-reset and back-to-back sequences.
module tb_enc_param_serial;

  logic       clk;
  logic       rst;
  logic [7:0] vec_in;
  logic       load;
  logic       busy;
  logic [2:0] idx_out;
  logic       valid;
  logic       ready;
  logic       done;
  logic       empty;
  logic [3:0] cnt;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] vec;
    int         n_idx;
    int         idx [8];
  } vec_t;

  vec_t tbl [8];

  enc_param_serial #(.n(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .vec_in  (vec_in),
    .load    (load),
    .busy    (busy),
    .idx_out (idx_out),
    .valid   (valid),
    .ready   (ready),
    .done    (done),
    .empty   (empty),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    vec_in = v.vec;
    load   = 1'b1;
    ready  = 1'b1;
    tick();
    load   = 1'b0;
    vec_in = 8'h00;
    for (int k = 0; k < v.n_idx; k++) begin
      chk("valid", int'(valid), 1);
      chk("busy", int'(busy), 1);
      chk("idx", int'(idx_out), v.idx[k]);
      chk("no_done", int'(done), 0);
      tick();
    end
    chk("done", int'(done), 1);
    chk("valid_end", int'(valid), 0);
    chk("busy_end", int'(busy), 0);
    chk("cnt", int'(cnt), v.n_idx);
    chk("empty", int'(empty), (v.n_idx == 0) ? 1 : 0);
    tick();
    chk("done_pulse", int'(done), 0);
    chk("cnt_hold", int'(cnt), v.n_idx);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{8'hA4, 3, '{2, 5, 7, 0, 0, 0, 0, 0}};
    tbl[1] = '{8'h00, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[2] = '{8'hFF, 8, '{0, 1, 2, 3, 4, 5, 6, 7}};
    tbl[3] = '{8'h12, 2, '{1, 4, 0, 0, 0, 0, 0, 0}};
    tbl[4] = '{8'h80, 1, '{7, 0, 0, 0, 0, 0, 0, 0}};
    tbl[5] = '{8'h01, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[6] = '{8'h81, 2, '{0, 7, 0, 0, 0, 0, 0, 0}};
    tbl[7] = '{8'h5A, 4, '{1, 3, 4, 6, 0, 0, 0, 0}};

    rst    = 1'b1;
    load   = 1'b0;
    ready  = 1'b0;
    vec_in = 8'h00;
    #13;
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_empty", int'(empty), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_idx", int'(idx_out), 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    // ready stall: idx 1 held for 3 stalled cycles plus the accept
    vec_in = 8'h12;
    load   = 1'b1;
    ready  = 1'b0;
    tick();
    load = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("stall_valid", int'(valid), 1);
      chk("stall_idx", int'(idx_out), 1);
      chk("stall_cnt", int'(cnt), 0);
      tick();
    end
    ready = 1'b1;
    chk("stall_idx_acc", int'(idx_out), 1);
    tick();
    chk("stall_idx2", int'(idx_out), 4);
    chk("stall_valid2", int'(valid), 1);
    tick();
    chk("stall_done", int'(done), 1);
    chk("stall_cnt_end", int'(cnt), 2);
    tick();

    // load during SCAN is ignored
    vec_in = 8'hFF;
    load   = 1'b1;
    tick();
    vec_in = 8'h01;
    for (int k = 0; k < 8; k++) begin
      chk("ign_idx", int'(idx_out), k);
      chk("ign_valid", int'(valid), 1);
      if (k == 7) load = 1'b0;
      tick();
    end
    chk("ign_done", int'(done), 1);
    chk("ign_cnt", int'(cnt), 8);
    tick();
    chk("ign_no_reemit", int'(valid), 0);
    chk("ign_busy", int'(busy), 0);

    // async reset mid-emission
    vec_in = 8'hF0;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("ar_idx4", int'(idx_out), 4);
    tick();
    chk("ar_idx5", int'(idx_out), 5);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", int'(valid), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_idx", int'(idx_out), 0);
    chk("ar_cnt", int'(cnt), 0);
    chk("ar_done", int'(done), 0);
    #2 rst = 1'b0;
    tick();
    chk("ar_no_done", int'(done), 0);
    chk("ar_idle", int'(valid), 0);
    vec_in = 8'h80;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("ar_idx7", int'(idx_out), 7);
    chk("ar_valid7", int'(valid), 1);
    tick();
    chk("ar_done2", int'(done), 1);
    chk("ar_cnt2", int'(cnt), 1);
    tick();

    // final accept then load in the done cycle
    vec_in = 8'h01;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("bb_idx0", int'(idx_out), 0);
    tick();
    chk("bb_done", int'(done), 1);
    chk("bb_cnt1", int'(cnt), 1);
    vec_in = 8'h03;
    load   = 1'b1;
    tick();
    load = 1'b0;
    chk("bb_done_end", int'(done), 0);
    chk("bb_cnt0", int'(cnt), 0);
    chk("bb_idx_a", int'(idx_out), 0);
    chk("bb_valid", int'(valid), 1);
    tick();
    chk("bb_idx_b", int'(idx_out), 1);
    tick();
    chk("bb_done2", int'(done), 1);
    chk("bb_cnt2", int'(cnt), 2);
    chk("bb_empty", int'(empty), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
